can_tx_scheduler: RTL and testbench
===================================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter NUM_MB, default 3, number of transmit mailboxes (2..4).
REQ-002 Parameter MAX_RETRY, default 7, number of arbitration-loss retries before failure; 0 means unlimited retries.
REQ-003 clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 sample_point  in  1  bit-timing strobe, shared with the transmitter.
REQ-006 wr_en / wr_mb / wr_addr / wr_data  in  1 / $clog2(NUM_MB) / 4 / 8  host byte write into mailbox wr_mb, byte index wr_addr (0..9).
REQ-007 req_set / req_abort  in  NUM_MB / NUM_MB  per-mailbox one-cycle pulses that request or abort transmission.
REQ-008 tx_done / arb_lost  in  1 / 1  transmitter frame-complete flag and arbitration-lost flag; both are valid only when sample_point=1.
REQ-009 start_tx  out  1  transmission request to the transmitter.
REQ-010 tx_data_0 .. tx_data_9  out  8 each  bytes of the selected mailbox.
REQ-011 tx_busy  out  1  high whenever state is not IDLE.
REQ-012 req_pending  out  NUM_MB  request flag of each mailbox.
REQ-013 tx_ok / tx_fail / tx_aborted  out  NUM_MB each  one-cycle per-mailbox completion pulses.

Function
REQ-014 Each mailbox SHALL hold 10 bytes in transmitter frame-byte layout; its priority key SHALL be the 11-bit value {byte0, byte1[7:5]}.
REQ-015 A write SHALL be ignored when the target mailbox has req_pending=1 or is the active mailbox; a write with wr_addr>9 SHALL be ignored.
REQ-016 req_set SHALL set req_pending on the next edge; setting an already-pending mailbox SHALL have no effect.
REQ-017 The FSM states SHALL be IDLE, SELECT, START, WAIT, and RESOLVE.
REQ-018 IDLE -> SELECT when any req_pending bit is 1.
REQ-019 SELECT (1 cycle) SHALL latch as the active mailbox the pending mailbox with the lowest key, breaking ties by the lowest index, SHALL clear its retry count on first selection, then go -> START.
REQ-020 START SHALL drive start_tx=1 until a cycle with sample_point=1, then go -> WAIT; start_tx SHALL be 0 in every other state.
REQ-021 tx_data_0..9 SHALL reflect the active mailbox from START through RESOLVE and SHALL be stable throughout; in IDLE they SHALL be 0.
REQ-022 WAIT: tx_done&sample_point SHALL select the ok outcome, and arb_lost&sample_point SHALL select the lost outcome; both go -> RESOLVE, and tx_done SHALL win if both are asserted together.
REQ-023 RESOLVE (1 cycle), ok outcome: pulse tx_ok[active], clear its pending bit, go -> IDLE.
REQ-024 RESOLVE, lost outcome: increment the 4-bit retry count (saturating).
REQ-025 RESOLVE, lost outcome, when MAX_RETRY!=0 and the count reaches MAX_RETRY: pulse tx_fail[active], clear pending, go -> IDLE.
REQ-026 RESOLVE, lost outcome, otherwise: go -> SELECT, so re-arbitration includes newly pending mailboxes.
REQ-027 req_abort on a non-active mailbox SHALL clear its pending bit next edge and pulse tx_aborted.
REQ-028 req_abort on the active mailbox SHALL be recorded and take effect at RESOLVE.
REQ-029 At RESOLVE, an ok outcome SHALL win over a recorded abort (tx_ok only); a lost outcome with a recorded abort SHALL pulse tx_aborted and go -> IDLE.
REQ-030 Simultaneous req_set and req_abort on the same mailbox: abort SHALL win.
REQ-031 Exactly one of tx_ok/tx_fail/tx_aborted SHALL pulse per completed request.

Reset
REQ-032 rst SHALL set state=IDLE, start_tx=0, tx_busy=0, all req_pending/tx_ok/tx_fail/tx_aborted=0, retry count=0, recorded abort=0, tx_data_*=0.
REQ-033 rst SHALL clear all mailbox contents to 0.
REQ-034 rst asserted mid-frame SHALL drop start_tx and all outputs to their reset values on the next edge.

Structure
REQ-035 The state enum and the mailbox byte count (10) SHALL live in the shared CAN package (can_defs).
REQ-036 The lowest-key selection SHALL be a sub-module can_prio_select (combinational, NUM_MB keys with valid bits in, winning index and valid out).

Verification
REQ-037 Load mb0 with id 0x123 and mb1 with id 0x045, pulse req_set=2'b11 -> mb1 is sent first, then mb0; tx_ok pulses in the order mb1, mb0.
REQ-038 Equal ids 0x100 in mb0 and mb2 -> mb0 is sent first.
REQ-039 MAX_RETRY=2 with arb_lost on every attempt -> two START phases, then tx_fail[active]=1 and req_pending cleared.
REQ-040 req_abort on the active mailbox during WAIT followed by tx_done -> tx_ok only, no tx_aborted.
REQ-041 Write to a pending mailbox -> contents unchanged (tx_data_0 keeps its old value when sent).
REQ-042 rst pulsed during WAIT -> next cycle start_tx=0, tx_busy=0, req_pending=0.

Source files
------------

// File: rtl/can_defs.sv
// Shared CAN transmit definitions: scheduler FSM states and mailbox geometry.
package can_defs;

    localparam int MB_BYTES = 10;   // bytes per mailbox, transmitter frame layout
    localparam int KEY_W    = 11;   // arbitration key {byte0, byte1[7:5]}
    localparam int ADDR_W   = 4;    // host byte-address width
    localparam int RETRY_W  = 4;    // saturating retry counter width

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        RESOLVE
    } state_e;

    typedef logic [MB_BYTES-1:0][7:0] mb_t;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Host-side bus of the CAN transmit scheduler: mailbox writes, request control
// and per-mailbox status/completion reporting.
interface can_tx_scheduler_if
    import can_defs::*;
#(
    parameter int NUM_MB = 3
) ();

    localparam int MB_W = $clog2(NUM_MB);

    logic              wr_en;
    logic [MB_W-1:0]   wr_mb;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [NUM_MB-1:0] req_set;
    logic [NUM_MB-1:0] req_abort;
    logic [NUM_MB-1:0] req_pending;
    logic [NUM_MB-1:0] tx_ok;
    logic [NUM_MB-1:0] tx_fail;
    logic [NUM_MB-1:0] tx_aborted;

    // Host side drives writes and requests, observes status.
    modport master (
        output wr_en, wr_mb, wr_addr, wr_data, req_set, req_abort,
        input  req_pending, tx_ok, tx_fail, tx_aborted
    );

    // Scheduler side.
    modport slave (
        input  wr_en, wr_mb, wr_addr, wr_data, req_set, req_abort,
        output req_pending, tx_ok, tx_fail, tx_aborted
    );

endinterface

// File: rtl/can_prio_select.sv
// Combinational lowest-key selector: among valid entries picks the smallest key,
// lowest index on ties (strict compare keeps the earlier index).
module can_prio_select #(
    parameter int N     = 3,
    parameter int KEY_W = 11,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0][KEY_W-1:0] keys_i,
    input  logic [N-1:0]            valid_i,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    valid_o
);

    logic [KEY_W-1:0] best;

    // Linear scan for the minimum key among valid entries.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        idx_o   = '0;
        valid_o = 1'b0;
        best    = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i] && (!valid_o || keys_i[i] < best)) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
                best    = keys_i[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: holds NUM_MB mailboxes, picks the pending one with the
// lowest arbitration key, hands it to the transmitter and resolves the outcome
// (ok / arbitration-loss retry / failure / abort).
module can_tx_scheduler
    import can_defs::*;
#(
    parameter int NUM_MB    = 3,
    parameter int MAX_RETRY = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_point,
    input  logic                tx_done,
    input  logic                arb_lost,
    can_tx_scheduler_if.slave   host,
    output logic                start_tx,
    output logic [7:0]          tx_data_0,
    output logic [7:0]          tx_data_1,
    output logic [7:0]          tx_data_2,
    output logic [7:0]          tx_data_3,
    output logic [7:0]          tx_data_4,
    output logic [7:0]          tx_data_5,
    output logic [7:0]          tx_data_6,
    output logic [7:0]          tx_data_7,
    output logic [7:0]          tx_data_8,
    output logic [7:0]          tx_data_9,
    output logic                tx_busy
);

    localparam int MB_W = $clog2(NUM_MB);

    state_e               state_q;
    logic [MB_W-1:0]      active_q;
    logic                 outcome_ok_q;   // RESOLVE outcome: 1 = frame done, 0 = arbitration lost
    logic                 abort_rec_q;    // abort requested on the mailbox currently on the bus
    logic                 resel_q;        // SELECT entered from RESOLVE (retry), not from IDLE
    logic [RETRY_W-1:0]   retry_q;
    logic                 start_tx_q;
    logic                 tx_busy_q;
    mb_t                  tx_data_q;

    mb_t                  mb_q [NUM_MB];
    logic [NUM_MB-1:0]    pending_q, pending_d;
    logic [NUM_MB-1:0]    tx_ok_q, tx_ok_d;
    logic [NUM_MB-1:0]    tx_fail_q, tx_fail_d;
    logic [NUM_MB-1:0]    tx_aborted_q, tx_aborted_d;

    logic [NUM_MB-1:0][KEY_W-1:0] keys;
    logic [MB_W-1:0]      sel_idx;
    logic                 sel_valid;

    logic                 on_bus;          // START..RESOLVE: active_q owns the transmitter
    logic [MB_W-1:0]      cur_act;         // mailbox treated as active this cycle
    logic                 cur_act_valid;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 eff_abort;
    logic                 retry_exhausted;

    // Arbitration keys straight from the identifier bytes of each mailbox.
    always_comb begin
        for (int i = 0; i < NUM_MB; i++) begin
            keys[i] = {mb_q[i][0], mb_q[i][1][7:5]};
        end
    end

    can_prio_select #(
        .N     (NUM_MB),
        .KEY_W (KEY_W),
        .IDX_W (MB_W)
    ) u_prio_select (
        .keys_i  (keys),
        .valid_i (pending_q),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // In SELECT the winner is about to be latched, so an abort aimed at it must be
    // recorded rather than applied as a plain pending clear.
    assign on_bus          = (state_q == START) || (state_q == WAIT) || (state_q == RESOLVE);
    assign cur_act         = (state_q == SELECT) ? sel_idx : active_q;
    assign cur_act_valid   = on_bus || ((state_q == SELECT) && sel_valid);
    assign retry_inc       = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    assign eff_abort       = abort_rec_q || host.req_abort[active_q];
    assign retry_exhausted = (MAX_RETRY != 0) && (int'(retry_inc) >= MAX_RETRY);

    // Next pending flags and completion pulses from host requests and the RESOLVE outcome.
    always_comb begin
        pending_d    = pending_q;
        tx_ok_d      = '0;
        tx_fail_d    = '0;
        tx_aborted_d = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (cur_act_valid && (cur_act == MB_W'(i))) begin
                // Active mailbox is already pending; its abort is recorded by the FSM.
            end else if (host.req_abort[i]) begin
                pending_d[i]    = 1'b0;
                tx_aborted_d[i] = pending_q[i] || host.req_set[i];
            end else if (host.req_set[i]) begin
                pending_d[i] = 1'b1;
            end
        end
        if (state_q == RESOLVE) begin
            if (outcome_ok_q) begin
                tx_ok_d[active_q]   = 1'b1;
                pending_d[active_q] = 1'b0;
            end else if (eff_abort) begin
                tx_aborted_d[active_q] = 1'b1;
                pending_d[active_q]    = 1'b0;
            end else if (retry_exhausted) begin
                tx_fail_d[active_q] = 1'b1;
                pending_d[active_q] = 1'b0;
            end
        end
    end

    // Pending flags and one-cycle completion pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            pending_q    <= '0;
            tx_ok_q      <= '0;
            tx_fail_q    <= '0;
            tx_aborted_q <= '0;
        end else begin
            pending_q    <= pending_d;
            tx_ok_q      <= tx_ok_d;
            tx_fail_q    <= tx_fail_d;
            tx_aborted_q <= tx_aborted_d;
        end
    end

    // Host byte writes; locked while the mailbox is pending or on the bus.
    always_ff @(posedge clk) begin
        // NOTE: mailbox storage is reset on purpose: a request on a never-written mailbox must send zeros.
        if (rst) begin
            for (int i = 0; i < NUM_MB; i++) begin
                mb_q[i] <= '0;
            end
        end else if (host.wr_en && (host.wr_addr < ADDR_W'(MB_BYTES))) begin
            for (int i = 0; i < NUM_MB; i++) begin
                if ((host.wr_mb == MB_W'(i)) && !pending_q[i] &&
                    !(on_bus && (active_q == MB_W'(i)))) begin
                    mb_q[i][host.wr_addr] <= host.wr_data;
                end
            end
        end
    end

    // Scheduler FSM with registered start_tx / tx_busy / tx_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            active_q     <= '0;
            outcome_ok_q <= 1'b0;
            abort_rec_q  <= 1'b0;
            resel_q      <= 1'b0;
            retry_q      <= '0;
            start_tx_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        state_q   <= SELECT;
                        tx_busy_q <= 1'b1;
                        resel_q   <= 1'b0;
                    end
                end
                SELECT: begin
                    if (sel_valid) begin
                        active_q    <= sel_idx;
                        tx_data_q   <= mb_q[sel_idx];
                        abort_rec_q <= host.req_abort[sel_idx];
                        if (!resel_q || (sel_idx != active_q)) begin
                            retry_q <= '0;
                        end
                        start_tx_q  <= 1'b1;
                        state_q     <= START;
                    end else begin
                        // Everything was aborted between IDLE and SELECT.
                        state_q   <= IDLE;
                        tx_busy_q <= 1'b0;
                    end
                end
                START: begin
                    abort_rec_q <= abort_rec_q || host.req_abort[active_q];
                    if (sample_point) begin
                        start_tx_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    abort_rec_q <= abort_rec_q || host.req_abort[active_q];
                    if (sample_point && tx_done) begin
                        outcome_ok_q <= 1'b1;
                        state_q      <= RESOLVE;
                    end else if (sample_point && arb_lost) begin
                        outcome_ok_q <= 1'b0;
                        state_q      <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    abort_rec_q <= 1'b0;
                    if (!outcome_ok_q) begin
                        retry_q <= retry_inc;
                    end
                    if (outcome_ok_q || eff_abort || retry_exhausted) begin
                        state_q   <= IDLE;
                        tx_busy_q <= 1'b0;
                        tx_data_q <= '0;
                    end else begin
                        // Re-arbitrate so newly pending mailboxes compete too.
                        state_q <= SELECT;
                        resel_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_tx         = start_tx_q;
    assign tx_busy          = tx_busy_q;
    assign tx_data_0        = tx_data_q[0];
    assign tx_data_1        = tx_data_q[1];
    assign tx_data_2        = tx_data_q[2];
    assign tx_data_3        = tx_data_q[3];
    assign tx_data_4        = tx_data_q[4];
    assign tx_data_5        = tx_data_q[5];
    assign tx_data_6        = tx_data_q[6];
    assign tx_data_7        = tx_data_q[7];
    assign tx_data_8        = tx_data_q[8];
    assign tx_data_9        = tx_data_q[9];
    assign host.req_pending = pending_q;
    assign host.tx_ok       = tx_ok_q;
    assign host.tx_fail     = tx_fail_q;
    assign host.tx_aborted  = tx_aborted_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: scripted host/transmitter stimulus with a
// scoreboard of expected frame starts and completion pulses.
module tb_can_tx_scheduler;

    localparam int NUM_MB    = 3;
    localparam int MAX_RETRY = 2;
    localparam int K_OK      = 0;
    localparam int K_FAIL    = 1;
    localparam int K_ABORT   = 2;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } frame_t;

    typedef struct {
        int kind;
        int mb;
    } done_t;

    logic clk;
    logic rst;
    logic sample_point;
    logic tx_done;
    logic arb_lost;
    logic start_tx;
    logic tx_busy;
    logic [7:0] tx_data_0, tx_data_1, tx_data_2, tx_data_3, tx_data_4;
    logic [7:0] tx_data_5, tx_data_6, tx_data_7, tx_data_8, tx_data_9;

    can_tx_scheduler_if #(.NUM_MB(NUM_MB)) host ();

    can_tx_scheduler #(
        .NUM_MB    (NUM_MB),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_point (sample_point),
        .tx_done      (tx_done),
        .arb_lost     (arb_lost),
        .host         (host),
        .start_tx     (start_tx),
        .tx_data_0    (tx_data_0),
        .tx_data_1    (tx_data_1),
        .tx_data_2    (tx_data_2),
        .tx_data_3    (tx_data_3),
        .tx_data_4    (tx_data_4),
        .tx_data_5    (tx_data_5),
        .tx_data_6    (tx_data_6),
        .tx_data_7    (tx_data_7),
        .tx_data_8    (tx_data_8),
        .tx_data_9    (tx_data_9),
        .tx_busy      (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    frame_t exp_start [$];
    done_t  exp_done  [$];

    logic  mon_p;
    done_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < NUM_MB; i++) begin
                    mon_p = (k == K_OK) ? host.tx_ok[i] :
                            (k == K_FAIL) ? host.tx_fail[i] : host.tx_aborted[i];
                    if (mon_p === 1'b1) begin
                        checks++;
                        if (exp_done.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_done: got kind=%0d mb=%0d, required no completion", k, i);
                        end else begin
                            mon_e = exp_done.pop_front();
                            if (mon_e.kind !== k || mon_e.mb !== i) begin
                                errors++;
                                $display("FAIL done_order: got kind=%0d mb=%0d, required kind=%0d mb=%0d",
                                         k, i, mon_e.kind, mon_e.mb);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t, required completion before 500000", $time);
        $fatal(1, "bench did not terminate");
    end

    function automatic frame_t fr(input logic [10:0] id, input logic [7:0] fill);
        frame_t f;
        f.b0 = id[10:3];
        f.b1 = {id[2:0], 5'b0};
        f.b2 = fill + 8'd2;
        return f;
    endfunction

    function automatic done_t dn(input int kind, input int mb);
        done_t d;
        d.kind = kind;
        d.mb   = mb;
        return d;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input int mb, input int addr, input logic [7:0] d);
        host.wr_mb   = 2'(mb);
        host.wr_addr = 4'(addr);
        host.wr_data = d;
        host.wr_en   = 1'b1;
        @(negedge clk);
        host.wr_en   = 1'b0;
    endtask

    task automatic load_id(input int mb, input logic [10:0] id, input logic [7:0] fill);
        write_byte(mb, 0, id[10:3]);
        write_byte(mb, 1, {id[2:0], 5'b0});
        for (int i = 2; i < 10; i++) write_byte(mb, i, fill + 8'(i));
    endtask

    task automatic pulse_set(input logic [NUM_MB-1:0] m);
        host.req_set = m;
        @(negedge clk);
        host.req_set = '0;
    endtask

    // Plays the transmitter for one frame; optional host set/abort during WAIT.
    task automatic serve(input bit lose, input logic [NUM_MB-1:0] ab, input logic [NUM_MB-1:0] st);
        frame_t e;
        int n;
        n = 0;
        while (start_tx !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (start_tx !== 1'b1) begin
            errors++;
            $display("FAIL start_wait: start_tx=%b after %0d cycles, required 1", start_tx, n);
            return;
        end
        checks++;
        if (exp_start.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: data0=%h, required no frame", tx_data_0);
            e = fr(11'h0, 8'h0);
        end else begin
            e = exp_start.pop_front();
            if ({tx_data_0, tx_data_1, tx_data_2} !== {e.b0, e.b1, e.b2}) begin
                errors++;
                $display("FAIL frame_data: got %h %h %h, required %h %h %h",
                         tx_data_0, tx_data_1, tx_data_2, e.b0, e.b1, e.b2);
            end
        end
        @(negedge clk);
        checks++;
        if (start_tx !== 1'b1) begin
            errors++;
            $display("FAIL start_hold: start_tx=%b, required 1", start_tx);
        end
        sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0;
        checks++;
        if (start_tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: start_tx=%b tx_busy=%b, required 0 1", start_tx, tx_busy);
        end
        host.req_abort = ab;
        host.req_set   = st;
        @(negedge clk);
        host.req_abort = '0;
        host.req_set   = '0;
        tx_done = 1'b1;                 // no sample point: must be ignored
        @(negedge clk);
        sample_point = 1'b1;
        tx_done      = !lose;
        arb_lost     = 1'b1;            // both high on ok frames: tx_done must win
        @(negedge clk);
        sample_point = 1'b0;
        tx_done      = 1'b0;
        arb_lost     = 1'b0;
        checks++;
        if ({tx_data_0, tx_data_1, tx_data_2} !== {e.b0, e.b1, e.b2}) begin
            errors++;
            $display("FAIL data_stable: got %h %h %h, required %h %h %h",
                     tx_data_0, tx_data_1, tx_data_2, e.b0, e.b1, e.b2);
        end
    endtask

    task automatic expect_drained(input string name);
        settle(4);
        checks++;
        if (exp_done.size() != 0 || exp_start.size() != 0 || tx_busy !== 1'b0 || host.req_pending !== '0) begin
            errors++;
            $display("FAIL %s_drained: left done=%0d start=%0d busy=%b pending=%b, required 0 0 0 000",
                     name, exp_done.size(), exp_start.size(), tx_busy, host.req_pending);
            exp_done.delete();
            exp_start.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        settle(3);
        checks++;
        if (start_tx !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: start_tx=%b tx_busy=%b, required 0 0", start_tx, tx_busy);
        end
        checks++;
        if (host.req_pending !== '0 || (host.tx_ok | host.tx_fail | host.tx_aborted) !== '0) begin
            errors++;
            $display("FAIL reset_flags: pending=%b pulses=%b, required 000 000",
                     host.req_pending, host.tx_ok | host.tx_fail | host.tx_aborted);
        end
        checks++;
        if (tx_data_0 !== 8'h00 || tx_data_9 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: data0=%h data9=%h, required 00 00", tx_data_0, tx_data_9);
        end
        rst = 1'b0;
        settle(2);
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: tx_busy=%b, required 0", tx_busy);
        end
    endtask

    task automatic test_priority();
        load_id(0, 11'h123, 8'h10);
        load_id(1, 11'h045, 8'h20);
        exp_start.push_back(fr(11'h045, 8'h20));
        exp_start.push_back(fr(11'h123, 8'h10));
        exp_done.push_back(dn(K_OK, 1));
        exp_done.push_back(dn(K_OK, 0));
        pulse_set(3'b011);
        checks++;
        if (host.req_pending !== 3'b011) begin
            errors++;
            $display("FAIL prio_pending: got %b, required 011", host.req_pending);
        end
        serve(1'b0, '0, '0);
        serve(1'b0, '0, '0);
        expect_drained("prio");
        checks++;
        if (tx_data_0 !== 8'h00) begin
            errors++;
            $display("FAIL idle_data: data0=%h, required 00", tx_data_0);
        end
    endtask

    task automatic test_tie();
        load_id(0, 11'h100, 8'h10);
        load_id(2, 11'h100, 8'h30);
        exp_start.push_back(fr(11'h100, 8'h10));
        exp_start.push_back(fr(11'h100, 8'h30));
        exp_done.push_back(dn(K_OK, 0));
        exp_done.push_back(dn(K_OK, 2));
        pulse_set(3'b101);
        serve(1'b0, '0, '0);
        serve(1'b0, '0, '0);
        expect_drained("tie");
    endtask

    task automatic test_retry_fail();
        bit extra;
        load_id(1, 11'h200, 8'h40);
        exp_start.push_back(fr(11'h200, 8'h40));
        exp_start.push_back(fr(11'h200, 8'h40));
        exp_done.push_back(dn(K_FAIL, 1));
        pulse_set(3'b010);
        serve(1'b1, '0, '0);
        serve(1'b1, '0, '0);
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (start_tx === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL retry_limit: third start_tx seen=%b, required 0", extra);
        end
        expect_drained("retry");
    endtask

    task automatic test_abort_nonactive();
        load_id(0, 11'h300, 8'h50);
        load_id(1, 11'h010, 8'h60);
        load_id(2, 11'h301, 8'h70);
        exp_start.push_back(fr(11'h010, 8'h60));
        exp_done.push_back(dn(K_ABORT, 0));
        exp_done.push_back(dn(K_ABORT, 2));
        exp_done.push_back(dn(K_OK, 1));
        pulse_set(3'b111);
        serve(1'b0, 3'b101, 3'b001);   // mb0: set+abort together, mb2: plain abort
        expect_drained("abort_na");
    endtask

    task automatic test_abort_lost();
        exp_start.push_back(fr(11'h010, 8'h60));
        exp_done.push_back(dn(K_ABORT, 1));
        pulse_set(3'b010);
        serve(1'b1, 3'b010, '0);
        expect_drained("abort_lost");
    endtask

    task automatic test_abort_active();
        load_id(2, 11'h050, 8'h80);
        exp_start.push_back(fr(11'h050, 8'h80));
        exp_done.push_back(dn(K_OK, 2));
        pulse_set(3'b100);
        serve(1'b0, 3'b100, '0);
        expect_drained("abort_ok");
    endtask

    task automatic test_write_protect();
        frame_t f;
        load_id(0, 11'h123, 8'h40);
        write_byte(0, 10, 8'h55);          // out of range: ignored
        exp_start.push_back(fr(11'h123, 8'h40));
        exp_done.push_back(dn(K_OK, 0));
        pulse_set(3'b001);
        write_byte(0, 0, 8'hFF);           // pending: ignored
        write_byte(0, 2, 8'hEE);
        serve(1'b0, '0, '0);
        expect_drained("wprot");
        write_byte(0, 0, 8'h7E);           // idle again: accepted
        f = fr(11'h123, 8'h40);
        f.b0 = 8'h7E;
        exp_start.push_back(f);
        exp_done.push_back(dn(K_OK, 0));
        pulse_set(3'b001);
        serve(1'b0, '0, '0);
        expect_drained("wopen");
    endtask

    task automatic test_reset_mid();
        int n;
        load_id(2, 11'h3FF, 8'h20);
        pulse_set(3'b100);
        n = 0;
        while (start_tx !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (start_tx !== 1'b1 || {tx_data_0, tx_data_1} !== 16'h7FE0) begin
            errors++;
            $display("FAIL rmid_start: start_tx=%b data=%h%h, required 1 7fe0", start_tx, tx_data_0, tx_data_1);
        end
        sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (start_tx !== 1'b0 || tx_busy !== 1'b0 || host.req_pending !== '0 || tx_data_0 !== 8'h00) begin
            errors++;
            $display("FAIL rmid_outputs: start_tx=%b busy=%b pending=%b data0=%h, required 0 0 000 00",
                     start_tx, tx_busy, host.req_pending, tx_data_0);
        end
        rst = 1'b0;
        settle(2);
        exp_start.push_back(fr(11'h000, 8'hFE));   // cleared mailbox: all-zero bytes
        exp_done.push_back(dn(K_OK, 2));
        pulse_set(3'b100);
        serve(1'b0, '0, '0);
        expect_drained("rmid");
    endtask

    initial begin
        rst            = 1'b1;
        sample_point   = 1'b0;
        tx_done        = 1'b0;
        arb_lost       = 1'b0;
        host.wr_en     = 1'b0;
        host.wr_mb     = '0;
        host.wr_addr   = '0;
        host.wr_data   = '0;
        host.req_set   = '0;
        host.req_abort = '0;
        test_reset();
        test_priority();
        test_tie();
        test_retry_fail();
        test_abort_nonactive();
        test_abort_lost();
        test_abort_active();
        test_write_protect();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
